// File: rtl/btn_debounce_array.sv
// Per-channel button conditioner: 2-flop sync, stability-window debounce,
// registered press/release strobes and hold-to-repeat strobes.
module btn_debounce_array #(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_stb,
  output logic [N_BTN-1:0] repeat_stb
);

  localparam int SW    = $clog2(STABLE_CYCLES + 1);
  localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW    = $clog2(R_MAX + 1);

  localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED_WAIT,
    REPEATING
  } state_t;

  logic   [N_BTN-1:0]         s1;
  logic   [N_BTN-1:0]         s2;
  logic   [N_BTN-1:0][SW-1:0] stab_cnt;
  logic   [N_BTN-1:0][SW-1:0] stab_nxt;
  logic   [N_BTN-1:0][HW-1:0] hold_cnt;
  logic   [N_BTN-1:0][HW-1:0] hold_nxt;
  state_t [N_BTN-1:0]         state;
  state_t [N_BTN-1:0]         state_nxt;
  logic   [N_BTN-1:0]         level_nxt;
  logic   [N_BTN-1:0]         press_nxt;
  logic   [N_BTN-1:0]         release_nxt;
  logic   [N_BTN-1:0]         repeat_nxt;
  logic   [N_BTN-1:0]         flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      level       <= '0;
      press       <= '0;
      release_stb <= '0;
      repeat_stb  <= '0;
      stab_cnt    <= '0;
      hold_cnt    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= RELEASED;
      end
    end else begin
      s1          <= btn;
      s2          <= s1;
      level       <= level_nxt;
      press       <= press_nxt;
      release_stb <= release_nxt;
      repeat_stb  <= repeat_nxt;
      stab_cnt    <= stab_nxt;
      hold_cnt    <= hold_nxt;
      state       <= state_nxt;
    end
  end

  always_comb begin
    flip        = '0;
    level_nxt   = level;
    press_nxt   = '0;
    release_nxt = '0;
    repeat_nxt  = '0;
    stab_nxt    = '0;
    hold_nxt    = '0;
    state_nxt   = state;
    for (int i = 0; i < N_BTN; i++) begin
      // Any matching cycle restarts the window; the STABLE_CYCLES-th mismatch flips level.
      flip[i] = (s2[i] != level[i]) && (stab_cnt[i] == STAB_LAST);
      if (flip[i]) begin
        level_nxt[i]   = s2[i];
        press_nxt[i]   = s2[i];
        release_nxt[i] = ~s2[i];
      end else if (s2[i] != level[i]) begin
        stab_nxt[i] = stab_cnt[i] + SW'(1);
      end

      // Hold counter stays 0 outside the held states, so a press edge always restarts timing.
      case (state[i])
        RELEASED: begin
          if (press_nxt[i]) state_nxt[i] = PRESSED_WAIT;
        end
        PRESSED_WAIT: begin
          if (release_nxt[i]) begin
            state_nxt[i] = RELEASED;
          end else if (REPEAT_DELAY != 0) begin
            if (hold_cnt[i] == DELAY_LAST) begin
              repeat_nxt[i] = 1'b1;
              state_nxt[i]  = REPEATING;
            end else begin
              hold_nxt[i] = hold_cnt[i] + HW'(1);
            end
          end
        end
        REPEATING: begin
          if (release_nxt[i]) begin
            state_nxt[i] = RELEASED;
          end else if (hold_cnt[i] == PERIOD_LAST) begin
            repeat_nxt[i] = 1'b1;
          end else begin
            hold_nxt[i] = hold_cnt[i] + HW'(1);
          end
        end
        default: state_nxt[i] = RELEASED;
      endcase
    end
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised multi-channel push-button conditioner for the board's user buttons. Each channel synchronises a raw button input, debounces it with a programmable stability window, and produces a clean level, one-cycle press and release strobes, and optional hold-to-repeat strobes. It sits between the raw button pins and the cube-control logic, which consumes only the strobes.

## Interface
- `N_BTN`, 5: number of independent button channels.
- `STABLE_CYCLES`, 2_000_000: consecutive cycles the synchronised input must differ from `level` before `level` flips (20 ms at 100 MHz); must be ≥1.
- `REPEAT_DELAY`, 50_000_000: cycles from the press strobe to the first repeat strobe. A value of 0 disables auto-repeat.
- `REPEAT_PERIOD`, 10_000_000: cycles between successive repeat strobes; must be ≥1.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `btn` in N_BTN: raw, asynchronous, active-high button inputs.
- `level` out N_BTN: debounced button state; 1 means held.
- `press` out N_BTN: one-cycle strobe on each debounced 0→1 transition.
- `release` out N_BTN: one-cycle strobe on each debounced 1→0 transition.
- `repeat` out N_BTN: one-cycle strobe on each auto-repeat tick while the button is held.

## Operation
- Channels are fully independent; there is no cross-channel interaction.
- Synchroniser: two flops per channel (`btn`→`s1`→`s2`). Only `s2` is used downstream.
- Stability counter:
  - Width is `$clog2(STABLE_CYCLES+1)`.
  - If `s2 == level`, the counter is cleared to 0.
  - Otherwise it increments. On the edge where it equals `STABLE_CYCLES-1` (the STABLE_CYCLES-th consecutive mismatch), `level <= s2` and the counter is cleared.
  - A single matching cycle restarts the window. Glitches shorter than STABLE_CYCLES never change `level`.
- Strobes are registered:
  - `press` is high in exactly the cycle `level` first reads 1.
  - `release` is high in exactly the cycle `level` first reads 0.
- Auto-repeat (REPEAT_DELAY>0), per-channel hold counter:
  - It is cleared on the press edge and counts while `level`=1.
  - The first `repeat` strobe comes REPEAT_DELAY cycles after the `press` cycle.
  - Later strobes come every REPEAT_PERIOD cycles after that while `level` stays 1.
  - The counter width covers max(REPEAT_DELAY, REPEAT_PERIOD).
  - The counter is held at 0 while `level`=0.
- Per-channel state: RELEASED (level 0) → PRESSED_WAIT (level 1, before first repeat) → REPEATING (level 1, periodic) → RELEASED on the debounced release.
  - With REPEAT_DELAY=0, the channel stays in PRESSED_WAIT while held.
- Boundary rules:
  - `repeat` never asserts in the same cycle as `press` or `release`.
  - On release, the hold counter clears. A repeat that would fall on or after the release cycle is suppressed.
  - A new press restarts the REPEAT_DELAY timing from zero.
  - `press` and `release` on one channel are never both high.
  - Multiple channels may strobe in the same cycle.

## Timing
- Reset: synchronous. On the edge where `rst`=1, all of the following clear to 0:
  - `s1`, `s2`, `level`
  - the stability and hold counters
  - `press`, `release`, `repeat`
- Reset overrides all activity, including a channel mid-window or mid-repeat.
- After reset, `level` is 0 (released). A button held through reset produces a `press` after the normal latency once `rst` deasserts.
- Latency: `level` (and `press`/`release`) change on the (STABLE_CYCLES+2)-th clock edge, counting the first edge that samples the new `btn` value, provided `btn` stays stable.
- Strobe width: exactly one cycle each.
- Repeat spacing: a `press` at cycle P gives `repeat` at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD for k≥1, while held.

## Test plan
Parameters: N_BTN=3, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- **Clean press/release:** drive `btn[0]` 0→1 sampled at edge E, held 30 cycles, then 1→0.
  - `press[0]` fires for exactly one cycle on edge E+5, and `level[0]` goes 1 on the same edge.
  - `release[0]` fires one cycle on the 6th edge after the sampled 1→0.
- **Bounce rejection:** toggle `btn[1]` high for 3 cycles, low for 1, repeated 5 times, then hold high.
  - No `press[1]` during the bounce.
  - Exactly one `press[1]` on the 6th edge after the final stable rise.
- **Auto-repeat:** hold `btn[0]` with `press` at cycle P.
  - `repeat[0]` fires at P+10, P+13, P+16.
  - Release before P+19 gives no further repeats.
  - `release` never coincides with `repeat`.
- **Re-press timing:** release, then re-press.
  - The first `repeat` again lands exactly 10 cycles after the new `press`.
- **Channel independence:** press `btn[0]` and `btn[2]` on the same edge, with `btn[1]` idle.
  - `press[0]` and `press[2]` fire in the same cycle.
  - `level[1]` and all channel-1 strobes stay 0.
- **Reset mid-operation:** assert `rst` for 1 cycle during REPEATING with `btn[0]` still high.
  - All outputs are 0 on the next edge.
  - `press[0]` fires again 6 edges after `rst` deasserts.
  - No `repeat[0]` fires before P'+10, where P' is the cycle of the new `press[0]`.
